// File: rtl/lbm_step_sequencer_if.sv
// Host/memory-control bundle for the LBM phase sequencer.
// Latency: none, plain wires; the slave modport is the sequencer, the master modport the host/bench.
// Backpressure: stall (master -> slave) freezes address issue and the write-delay pipeline.
// Ports: start/num_iter/stall in; busy/done/phase/rd_*/wr_addr/WE_*_mem/select_init/iter_count out.
// LBM_SEQ_PERF_EN adds cycle_count.
interface lbm_step_sequencer_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int ITER_WIDTH    = 16
);
  logic                     start;
  logic [ITER_WIDTH-1:0]    num_iter;
  logic                     stall;
  logic                     busy;
  logic                     done;
  logic [2:0]               phase;
  logic [ADDRESS_WIDTH-1:0] rd_addr;
  logic                     rd_valid;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic                     WE_p_mem;
  logic                     WE_ux_mem;
  logic                     WE_uy_mem;
  logic                     WE_fin_mem;
  logic                     WE_fout_mem;
  logic                     WE_feq_mem;
  logic                     select_init;
  logic [ITER_WIDTH-1:0]    iter_count;
`ifdef LBM_SEQ_PERF_EN
  logic [31:0]              cycle_count;
`endif

  modport master (
`ifdef LBM_SEQ_PERF_EN
    input  cycle_count,
`endif
    output start, num_iter, stall,
    input  busy, done, phase, rd_addr, rd_valid, wr_addr,
    input  WE_p_mem, WE_ux_mem, WE_uy_mem, WE_fin_mem, WE_fout_mem, WE_feq_mem,
    input  select_init, iter_count
  );

  modport slave (
`ifdef LBM_SEQ_PERF_EN
    output cycle_count,
`endif
    input  start, num_iter, stall,
    output busy, done, phase, rd_addr, rd_valid, wr_addr,
    output WE_p_mem, WE_ux_mem, WE_uy_mem, WE_fin_mem, WE_fout_mem, WE_feq_mem,
    output select_init, iter_count
  );
endinterface

// File: rtl/lbm_step_sequencer.sv
// Phase sequencer: INIT once, then MOMENT->EQUIL->COLLIDE->STREAM per timestep, sweeping GRID_DIM cells per phase.
// Latency: writes trail reads by PIPE_LAT advancing cycles; each phase lasts GRID_DIM+PIPE_LAT non-stalled cycles.
// Backpressure: stall freezes address issue and the delay pipeline and masks all write enables.
// Ports: Clk, Reset (sync, active-high) plain; everything else on bus (lbm_step_sequencer_if.slave).
// Optional: define LBM_SEQ_PERF_EN to add bus.cycle_count, a saturating count of busy cycles.
module lbm_step_sequencer #(
  parameter int GRID_DIM      = 256,
  parameter int ADDRESS_WIDTH = $clog2(GRID_DIM),
  parameter int PIPE_LAT      = 4,
  parameter int ITER_WIDTH    = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  lbm_step_sequencer_if.slave   bus
);

  // Encodings of the phase states equal the values reported on bus.phase.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_MOMENT  = 3'd2,
    S_EQUIL   = 3'd3,
    S_COLLIDE = 3'd4,
    S_STREAM  = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  typedef struct packed {
    logic                     vld;
    logic [ADDRESS_WIDTH-1:0] addr;
  } stage_t;

  localparam int                       STAGE_W   = ADDRESS_WIDTH + 1;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(GRID_DIM - 1);

  state_t                   state, state_nxt;
  logic                     draining;
  logic [ADDRESS_WIDTH-1:0] rd_cnt;
  stage_t [PIPE_LAT-1:0]    pipe;
  logic [ITER_WIDTH-1:0]    num_iter_q;
  logic [ITER_WIDTH-1:0]    iter_cnt;

  logic                     in_phase;
  logic                     adv;
  logic                     rd_vld;
  logic                     wr_fire;
  logic                     last_wr;
  logic                     accept;
  logic [ITER_WIDTH-1:0]    iter_inc;
  stage_t                   head;
  logic [(PIPE_LAT+1)*STAGE_W-1:0] shifted;

  assign in_phase = (state == S_INIT) || (state == S_MOMENT) || (state == S_EQUIL) ||
                    (state == S_COLLIDE) || (state == S_STREAM);
  assign adv      = ~bus.stall;
  assign rd_vld   = in_phase & ~draining;
  assign wr_fire  = in_phase & pipe[PIPE_LAT-1].vld & adv;
  // The last write of a sweep is always the tail holding the top address; phases never overlap.
  assign last_wr  = wr_fire & (pipe[PIPE_LAT-1].addr == LAST_ADDR);
  assign iter_inc = iter_cnt + 1'b1;
  assign head     = '{vld: rd_vld, addr: rd_cnt};
  // Packed shift that also works for PIPE_LAT == 1: drop the old tail, insert head at stage 0.
  assign shifted  = {pipe, head};

  always_comb begin
    state_nxt       = state;
    accept          = 1'b0;
    bus.WE_p_mem    = 1'b0;
    bus.WE_ux_mem   = 1'b0;
    bus.WE_uy_mem   = 1'b0;
    bus.WE_fin_mem  = 1'b0;
    bus.WE_fout_mem = 1'b0;
    bus.WE_feq_mem  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = S_INIT;
        end
      end
      S_INIT: begin
        bus.WE_p_mem   = wr_fire;
        bus.WE_ux_mem  = wr_fire;
        bus.WE_uy_mem  = wr_fire;
        bus.WE_fin_mem = wr_fire;
        if (last_wr) state_nxt = (num_iter_q != '0) ? S_MOMENT : S_DONE;
      end
      S_MOMENT: begin
        bus.WE_p_mem  = wr_fire;
        bus.WE_ux_mem = wr_fire;
        bus.WE_uy_mem = wr_fire;
        if (last_wr) state_nxt = S_EQUIL;
      end
      S_EQUIL: begin
        bus.WE_feq_mem = wr_fire;
        if (last_wr) state_nxt = S_COLLIDE;
      end
      S_COLLIDE: begin
        bus.WE_fout_mem = wr_fire;
        if (last_wr) state_nxt = S_STREAM;
      end
      S_STREAM: begin
        bus.WE_fin_mem = wr_fire;
        if (last_wr) state_nxt = (iter_inc == num_iter_q) ? S_DONE : S_MOMENT;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      draining   <= 1'b0;
      rd_cnt     <= '0;
      pipe       <= '0;
      num_iter_q <= '0;
      iter_cnt   <= '0;
    end else begin
      if (accept) begin
        num_iter_q <= bus.num_iter;
        iter_cnt   <= '0;
      end else if (last_wr && state == S_STREAM) begin
        iter_cnt <= iter_inc;
      end
      // Address counter rewinds only at phase boundaries; the top address is issued exactly once.
      if (last_wr) begin
        draining <= 1'b0;
        rd_cnt   <= '0;
      end else if (rd_vld && adv) begin
        if (rd_cnt == LAST_ADDR) draining <= 1'b1;
        else                     rd_cnt   <= rd_cnt + 1'b1;
      end
      if (adv) pipe <= shifted[PIPE_LAT*STAGE_W-1:0];
    end
  end

`ifdef LBM_SEQ_PERF_EN
  logic [31:0] cycle_cnt;
  always_ff @(posedge Clk) begin
    if (Reset || accept)                  cycle_cnt <= '0;
    else if (in_phase && cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
  end
  assign bus.cycle_count = cycle_cnt;
`endif

  assign bus.busy        = in_phase;
  assign bus.done        = (state == S_DONE);
  assign bus.phase       = in_phase ? state : 3'd0;
  assign bus.rd_addr     = rd_cnt;
  assign bus.rd_valid    = rd_vld;
  assign bus.wr_addr     = pipe[PIPE_LAT-1].addr;
  assign bus.select_init = (state == S_INIT);
  assign bus.iter_count  = iter_cnt;

endmodule

// File: tb/tb_lbm_step_sequencer.sv
// Self-checking bench for lbm_step_sequencer (GRID_DIM=16, PIPE_LAT=4).
// Expected writes are queued per run from the phase table and popped as write enables fire.
module tb_lbm_step_sequencer;
  localparam int G  = 16;
  localparam int PL = 4;
  localparam int AW = 4;
  localparam int IW = 16;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  lbm_step_sequencer_if #(.ADDRESS_WIDTH(AW), .ITER_WIDTH(IW)) bus ();

  lbm_step_sequencer #(.GRID_DIM(G), .ADDRESS_WIDTH(AW), .PIPE_LAT(PL), .ITER_WIDTH(IW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {p, ux, uy, fin, fout, feq}
  wire [5:0] we = {bus.WE_p_mem, bus.WE_ux_mem, bus.WE_uy_mem,
                   bus.WE_fin_mem, bus.WE_fout_mem, bus.WE_feq_mem};

  function automatic logic [5:0] phase_mask(input int ph);
    case (ph)
      1:       return 6'b111100;
      2:       return 6'b111000;
      3:       return 6'b000001;
      4:       return 6'b000010;
      5:       return 6'b000100;
      default: return 6'b000000;
    endcase
  endfunction

  logic [12:0] sb_q[$];

  task automatic push_phase(input int ph);
    for (int a = 0; a < G; a++) sb_q.push_back({3'(ph), 4'(a), phase_mask(ph)});
  endtask

  task automatic push_run(input int n);
    push_phase(1);
    for (int it = 0; it < n; it++)
      for (int ph = 2; ph <= 5; ph++) push_phase(ph);
  endtask

  int feq_cnt  = 0;
  int stall_we = 0;

  always @(negedge Clk) begin
    if (!Reset && we != 6'b0) begin
      if (bus.stall) stall_we++;
      if (we[0]) feq_cnt++;
      if (sb_q.size() == 0) chk("wr_unexpected", {bus.phase, bus.wr_addr, we}, 64'd0);
      else                  chk("wr", {bus.phase, bus.wr_addr, we}, sb_q.pop_front());
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    chk(tag, {bus.busy, bus.done, bus.phase, bus.rd_addr, bus.rd_valid, bus.wr_addr,
              we, bus.select_init, bus.iter_count}, 64'd0);
  endtask

  task automatic run(input int n, input bit do_stall, input bit do_glitch);
    int          dur[6];
    int          first_we, done_idx, stall_left, exp_done;
    bit          stalled_once, sel_bad, busy_bad, hold_bad;
    logic [63:0] seq, exp_seq;
    logic [2:0]  ph, last_ph;

    sb_q.delete();
    push_run(n);
    feq_cnt = 0; stall_we = 0;
    foreach (dur[i]) dur[i] = 0;
    first_we = -1; done_idx = -1; stall_left = 0;
    stalled_once = 0; sel_bad = 0; busy_bad = 0; hold_bad = 0;
    seq = '0; last_ph = 3'd0;

    exp_seq = 64'h1;
    for (int it = 0; it < n; it++) exp_seq = {exp_seq[47:0], 16'h2345};
    exp_seq = {exp_seq[59:0], 4'h0};
    exp_done = 20 + 80 * n + (do_stall ? 3 : 0);

    bus.num_iter = IW'(n);
    bus.start    = 1'b1;
    step();
    bus.start    = 1'b0;
    bus.num_iter = IW'(n + 7);   // must be ignored after latch

    for (int idx = 0; idx < 2000; idx++) begin
      ph = bus.phase;
      if (ph != last_ph) seq = {seq[59:0], 1'b0, ph};
      last_ph = ph;
      if (bus.select_init !== (ph == 3'd1)) sel_bad = 1;
      if (bus.busy !== (ph != 3'd0)) busy_bad = 1;
      if (ph != 3'd0 && ph <= 3'd5) dur[ph]++;
      if (ph == 3'd1 && first_we < 0 && we != 6'b0) first_we = idx;
      if (idx == 0) chk("entry", {bus.phase, bus.rd_valid, bus.rd_addr}, {3'd1, 1'b1, 4'd0});

      if (do_stall && !stalled_once && ph == 3'd3 && bus.rd_valid && bus.rd_addr == 4'(G - 1)) begin
        stall_left   = 3;
        stalled_once = 1;
      end
      if (stall_left > 0) begin
        if (bus.rd_addr != 4'(G - 1) || !bus.rd_valid) hold_bad = 1;
        bus.stall = 1'b1;
        stall_left--;
      end else begin
        bus.stall = 1'b0;
      end

      bus.start = (do_glitch && idx == 50);

      if (bus.done) begin
        done_idx = idx;
        break;
      end
      step();
    end
    bus.stall = 1'b0;
    bus.start = 1'b0;

    chk("done_time", done_idx, exp_done);
    chk("phase_seq", seq, exp_seq);
    chk("iter_count", bus.iter_count, n);
    chk("dur_init", dur[1], 20);
    chk("dur_moment", dur[2], 20 * n);
    chk("dur_equil", dur[3], 20 * n + (do_stall ? 3 : 0));
    chk("dur_collide", dur[4], 20 * n);
    chk("dur_stream", dur[5], 20 * n);
    chk("first_we_idx", first_we, PL);
    chk("select_init", sel_bad, 0);
    chk("busy", busy_bad, 0);
    chk("feq_writes", feq_cnt, 16 * n);
    chk("sb_left", sb_q.size(), 0);
    if (do_stall) begin
      chk("stall_hold", hold_bad, 0);
      chk("we_in_stall", stall_we, 0);
      chk("stall_seen", stalled_once, 1);
    end
    step();
    chk("done_pulse", {bus.done, bus.busy, bus.phase}, 5'd0);
    chk("iter_hold", bus.iter_count, n);
  endtask

  initial begin
    int waited;
    Reset = 1'b1;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    bus.num_iter = '0;
    repeat (3) step();
    check_idle_zero("reset_state");
    Reset = 1'b0;
    bus.stall = 1'b1;            // stall in IDLE must not matter
    repeat (2) step();
    check_idle_zero("idle_state");
    bus.stall = 1'b0;

    run(1, 1'b0, 1'b0);          // single timestep
    run(0, 1'b0, 1'b0);          // INIT only
    run(1, 1'b1, 1'b0);          // stall on last EQUIL address

    // Reset in the second COLLIDE phase; in-flight writes are discarded.
    sb_q.delete();
    push_run(2);
    bus.num_iter = 16'd2;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    waited = 0;
    while (!(bus.phase == 3'd4 && bus.iter_count == 16'd1) && waited < 1000) begin
      step();
      waited++;
    end
    chk("reach_collide", waited < 1000, 1);
    repeat (6) step();
    Reset = 1'b1;
    step();
    check_idle_zero("mid_reset");
    Reset = 1'b0;
    sb_q.delete();
    step();
    run(0, 1'b0, 1'b0);          // restart after reset begins cleanly

    run(3, 1'b0, 1'b1);          // start pulsed while busy
`ifdef LBM_SEQ_PERF_EN
    chk("cycle_count", bus.cycle_count, 260);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
